audio_source_arbiter: RTL
=========================

// Module: audio_source_arbiter
// PURPOSE
//  Shares the speaker datapath between two PCM sources: music (low priority) and sound effects (high priority).
//  Drives audio_in_left/right of the I2S speaker controller and paces each source with a per-frame sample handshake.
//  Locks to the speaker controller's audio_lrck. Applies volume/mute, inserts silent gap frames on source switch.
// PARAMETERS
//  DATA_W      16  sample width per channel, two's complement
//  GAP_FRAMES  4   silent frames inserted on music<->sfx switch (0 = switch directly)
//  VOL_W       3   width of volume attenuation (arithmetic right-shift amount)
// PORTS
//  clk             in   1       system clock; same clock as the speaker controller
//  rst             in   1       synchronous reset, active-low
//  audio_lrck      in   1       LR clock from the speaker controller (512-clk period)
//  mus_req         in   1       music source requests the speaker
//  mus_valid       in   1       mus_left/right hold a valid sample
//  mus_left        in   DATA_W  music left sample
//  mus_right       in   DATA_W  music right sample
//  mus_ack         out  1       1-clk pulse: music sample consumed
//  sfx_req         in   1       sfx source requests the speaker
//  sfx_valid       in   1       sfx_left/right hold a valid sample
//  sfx_left        in   DATA_W  sfx left sample
//  sfx_right       in   DATA_W  sfx right sample
//  sfx_ack         out  1       1-clk pulse: sfx sample consumed
//  volume          in   VOL_W   attenuation: output = sample >>> volume
//  mute            in   1       force output to zero
//  audio_in_left   out  DATA_W  to speaker controller, left
//  audio_in_right  out  DATA_W  to speaker controller, right
//  grant           out  2       00 none/gap, 01 music, 10 sfx
//  underrun_cnt    out  8       saturating count of starved frames
// BEHAVIOUR
//  - Reset (rst==0 at posedge): all outputs 0, state IDLE, gap counter 0, lrck history 0.
//  - Slot: cycle t where lrck_q==1 && audio_lrck==0 (lrck_q = audio_lrck registered). One slot per frame.
//    Falling edge is mid-frame, so outputs are stable well before the controller latches on the lrck rise.
//  - All decisions occur only at slots; between slots, outputs and state hold. Stuck lrck -> no slots.
//  - FSM, evaluated at a slot; the frame's sample comes from the NEXT state:
//    IDLE : sfx_req -> SFX; else mus_req -> MUSIC; else IDLE.
//    MUSIC: sfx_req -> GAP(target SFX); else !mus_req -> IDLE; else MUSIC.
//    SFX  : sfx_req -> SFX; else mus_req -> GAP(target MUSIC); else IDLE. mus_req is ignored while in SFX.
//    GAP  : outputs 0, grant 00, no acks.
//           Decrements the counter from GAP_FRAMES; at count 1, goes to target if target req is still high,
//           else applies the IDLE rules. GAP_FRAMES==0 means GAP is never entered.
//    sfx_req going high during GAP(target MUSIC) retargets to SFX; the counter is not restarted.
//  - Consume, when the next state is MUSIC or SFX:
//    if the granted valid==1: audio_in_* <= mute ? 0 : sample >>> volume (sign-preserving).
//    The ack pulses high for the single cycle t+1.
//    if valid==0 (underrun): audio_in_* <= 0, no ack, underrun_cnt++ saturating at 255.
//  - Non-granted source never receives ack. IDLE/GAP slots drive audio_in_* <= 0.
//  - volume and mute are sampled at the slot only.
//  - grant is registered with the state; it changes on the same edge as audio_in_*.
//  - Reset mid-frame: everything clears on that edge; the first post-reset slot needs a fresh 1->0 lrck edge.
// STRUCTURE
//  - Shared package audio_pkg: DATA_W default, state encoding (IDLE, MUSIC, SFX, GAP),
//    and GRANT_NONE/GRANT_MUS/GRANT_SFX constants.
//  - Sub-module lrck_slot_gen: registers audio_lrck, emits the slot pulse; reset clears history.
//  - Top holds the FSM, gap counter, volume shift, ack and underrun logic.
// TESTING (bench models a 9-bit counter; lrck = cnt[8])
//  1. mus_req=1, valid=1, L=16'h4000, vol=0, first slot.
//     -> grant=01, audio_in_left=16'h4000, mus_ack one clk at slot+1.
//  2. Music playing, sfx_req rises.
//     -> next slot grant=00; 4 slots of zero output, no acks; 5th slot grant=10, sfx sample out.
//  3. vol=2, sample 16'h8000.
//     -> output 16'hE000; mute=1 -> 16'h0000, ack still issued.
//  4. Granted source valid=0 for 3 frames.
//     -> outputs 0, no ack, underrun_cnt=3; 300 starved frames -> 255.
//  5. sfx_req drops during GAP(target SFX) with mus_req=0.
//     -> IDLE at gap end, grant=00.
//  6. rst=0 mid-frame while in SFX -> all outputs 0 next edge; no ack until the next lrck 1->0 edge.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the two-source audio arbiter: sample width, FSM
// state encoding and the grant codes seen on the grant output.
package audio_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MUSIC = 2'd1,
      ST_SFX   = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_MUS  = 2'b01;
   localparam logic [1:0] GRANT_SFX  = 2'b10;

   function automatic logic [1:0] grant_of(input state_e st);
      case (st)
         ST_MUSIC: grant_of = GRANT_MUS;
         ST_SFX:   grant_of = GRANT_SFX;
         default:  grant_of = GRANT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/lrck_slot_gen.sv
// Turns the speaker controller's LR clock into a one-cycle slot pulse on its
// falling edge, i.e. mid-frame, once per frame.
module lrck_slot_gen (
   input  logic clk,
   input  logic rst,
   input  logic audio_lrck,
   output logic slot_o
);

   logic lrck_q;

   always_ff @(posedge clk) begin
      if (!rst) lrck_q <= 1'b0;
      else      lrck_q <= audio_lrck;
   end

   // History clears on reset, so the first slot afterwards needs a fresh 1->0 edge.
   assign slot_o = lrck_q & ~audio_lrck;

endmodule

// File: rtl/audio_source_arbiter.sv
// Arbitrates music and sound-effect PCM sources onto the speaker controller,
// one sample per frame, with silent gap frames on source switch.
module audio_source_arbiter
   import audio_pkg::*;
#(
   parameter int DATA_W     = audio_pkg::DATA_W,
   parameter int GAP_FRAMES = 4,
   parameter int VOL_W      = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              audio_lrck,
   input  logic              mus_req,
   input  logic              mus_valid,
   input  logic [DATA_W-1:0] mus_left,
   input  logic [DATA_W-1:0] mus_right,
   output logic              mus_ack,
   input  logic              sfx_req,
   input  logic              sfx_valid,
   input  logic [DATA_W-1:0] sfx_left,
   input  logic [DATA_W-1:0] sfx_right,
   output logic              sfx_ack,
   input  logic [VOL_W-1:0]  volume,
   input  logic              mute,
   output logic [DATA_W-1:0] audio_in_left,
   output logic [DATA_W-1:0] audio_in_right,
   output logic [1:0]        grant,
   output logic [7:0]        underrun_cnt
);

   localparam int GC_W = (GAP_FRAMES < 1) ? 1 : $clog2(GAP_FRAMES + 1);
   localparam logic [GC_W-1:0] GAP_LOAD = GC_W'(GAP_FRAMES);

   logic slot;

   state_e            state_q, state_d;
   state_e            target_q, target_d;
   logic [GC_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [DATA_W-1:0] left_q, left_d, right_q, right_d;
   logic [1:0]        grant_q, grant_d;
   logic              mus_ack_q, mus_ack_d, sfx_ack_q, sfx_ack_d;
   logic [7:0]        under_q, under_d;

   state_e            idle_next;
   state_e            gap_tgt;
   logic              gap_tgt_req;
   logic              sel_valid;
   logic [DATA_W-1:0] sel_left, sel_right;

   lrck_slot_gen u_slot (
      .clk        (clk),
      .rst        (rst),
      .audio_lrck (audio_lrck),
      .slot_o     (slot)
   );

   // sfx always wins from IDLE; music only when sfx is quiet.
   assign idle_next   = sfx_req ? ST_SFX : (mus_req ? ST_MUSIC : ST_IDLE);
   assign gap_tgt     = sfx_req ? ST_SFX : target_q;
   assign gap_tgt_req = (gap_tgt == ST_SFX) ? sfx_req : mus_req;

   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      gap_cnt_d = gap_cnt_q;
      left_d    = left_q;
      right_d   = right_q;
      grant_d   = grant_q;
      mus_ack_d = 1'b0;
      sfx_ack_d = 1'b0;
      under_d   = under_q;
      sel_valid = 1'b0;
      sel_left  = '0;
      sel_right = '0;

      if (slot) begin
         case (state_q)
            ST_IDLE: state_d = idle_next;
            ST_MUSIC: begin
               if (sfx_req) begin
                  if (GAP_FRAMES == 0) state_d = ST_SFX;
                  else begin
                     state_d   = ST_GAP;
                     target_d  = ST_SFX;
                     gap_cnt_d = GAP_LOAD;
                  end
               end else if (!mus_req) state_d = ST_IDLE;
            end
            ST_SFX: begin
               if (!sfx_req) begin
                  if (!mus_req) state_d = ST_IDLE;
                  else if (GAP_FRAMES == 0) state_d = ST_MUSIC;
                  else begin
                     state_d   = ST_GAP;
                     target_d  = ST_MUSIC;
                     gap_cnt_d = GAP_LOAD;
                  end
               end
            end
            default: begin
               // A rising sfx_req retargets the gap but keeps the count running.
               target_d = gap_tgt;
               if (gap_cnt_q <= GC_W'(1)) begin
                  gap_cnt_d = '0;
                  state_d   = gap_tgt_req ? gap_tgt : idle_next;
               end else begin
                  gap_cnt_d = gap_cnt_q - GC_W'(1);
               end
            end
         endcase

         grant_d = grant_of(state_d);
         left_d  = '0;
         right_d = '0;
         if (state_d == ST_MUSIC) begin
            sel_valid = mus_valid;
            sel_left  = mus_left;
            sel_right = mus_right;
         end else if (state_d == ST_SFX) begin
            sel_valid = sfx_valid;
            sel_left  = sfx_left;
            sel_right = sfx_right;
         end

         if (state_d == ST_MUSIC || state_d == ST_SFX) begin
            if (sel_valid) begin
               mus_ack_d = (state_d == ST_MUSIC);
               sfx_ack_d = (state_d == ST_SFX);
               if (!mute) begin
                  left_d  = $signed(sel_left) >>> volume;
                  right_d = $signed(sel_right) >>> volume;
               end
            end else if (under_q != 8'hFF) begin
               under_d = under_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         target_q  <= ST_IDLE;
         gap_cnt_q <= '0;
         left_q    <= '0;
         right_q   <= '0;
         grant_q   <= GRANT_NONE;
         mus_ack_q <= 1'b0;
         sfx_ack_q <= 1'b0;
         under_q   <= '0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         gap_cnt_q <= gap_cnt_d;
         left_q    <= left_d;
         right_q   <= right_d;
         grant_q   <= grant_d;
         mus_ack_q <= mus_ack_d;
         sfx_ack_q <= sfx_ack_d;
         under_q   <= under_d;
      end
   end

   assign audio_in_left  = left_q;
   assign audio_in_right = right_q;
   assign grant          = grant_q;
   assign mus_ack        = mus_ack_q;
   assign sfx_ack        = sfx_ack_q;
   assign underrun_cnt   = under_q;

endmodule
